// File: rtl/csr_test_monitor.sv
// csr_test_monitor: drives a reset into a DUT under test.
// It then watches NUM_CH CSR result channels until every channel has reported
// a nonzero value or the run times out.
//
// Handshake: start is a single-cycle request. It is accepted only in IDLE or
// DONE and ignored while busy. After acceptance, busy stays high until the run
// ends. Then done stays high, with pass/timeout/fail_mask valid, until the next
// accepted start or rst.
module csr_test_monitor #(
  parameter int                 NUM_CH          = 2,
  parameter int                 CSR_WIDTH       = 32,
  parameter logic [CSR_WIDTH-1:0] PASS_VALUE    = 1,
  parameter int                 RST_HOLD_CYCLES = 10,
  parameter int                 SETTLE_CYCLES   = 10,
  parameter int                 TIMEOUT_CYCLES  = 4_000_000,
  parameter int                 CNT_WIDTH       = 32,
  localparam int                SEL_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_CH*CSR_WIDTH-1:0] csr_in,
  input  logic [SEL_W-1:0]            csr_sel,
  output logic                        dut_rst,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic [NUM_CH-1:0]           reported,
  output logic [NUM_CH-1:0]           fail_mask,
  output logic [CSR_WIDTH-1:0]        csr_value,
  output logic [CNT_WIDTH-1:0]        cycle_count,
  output logic [2:0]                  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                 state;
  logic [31:0]            phase;
  logic [CSR_WIDTH-1:0]   cap [NUM_CH];
  logic [CSR_WIDTH-1:0]   csr_ch [NUM_CH];
  logic [NUM_CH-1:0]      new_cap;
  logic [NUM_CH-1:0]      new_fail;
  logic                   all_rep;
  logic                   any_fail;
  logic [CNT_WIDTH-1:0]   cc_next;
  logic                   timeout_hit;

  assign dbg_state = state;

  // Unpack the CSR bus, find first-time nonzero captures and evaluate completion.
  always_comb begin
    new_cap  = '0;
    new_fail = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      csr_ch[k]   = csr_in[k*CSR_WIDTH +: CSR_WIDTH];
      new_cap[k]  = (state == ST_WAIT) && !reported[k] && (csr_ch[k] != '0);
      new_fail[k] = (csr_ch[k] != PASS_VALUE);
    end
    // A channel counts as reported if it was latched earlier or is captured this cycle.
    all_rep  = &(reported | new_cap);
    any_fail = |(fail_mask | (new_fail & new_cap));
  end

  // Saturating next cycle count and the timeout condition it implies.
  always_comb begin
    cc_next     = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
    timeout_hit = (cc_next >= CNT_WIDTH'(TIMEOUT_CYCLES));
  end

  // Read back the captured value of the selected channel; out-of-range selects read 0.
  always_comb begin
    csr_value = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (csr_sel == SEL_W'(k)) csr_value = cap[k];
    end
  end

  // Run-sequencing FSM with registered outputs and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      phase       <= '0;
      dut_rst     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      reported    <= '0;
      fail_mask   <= '0;
      cycle_count <= '0;
      for (int k = 0; k < NUM_CH; k++) cap[k] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // A new run discards everything left over from the previous one.
            state       <= ST_HOLD;
            phase       <= 32'(RST_HOLD_CYCLES - 1);
            dut_rst     <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            reported    <= '0;
            fail_mask   <= '0;
            cycle_count <= '0;
            for (int k = 0; k < NUM_CH; k++) cap[k] <= '0;
          end
        end

        ST_HOLD: begin
          if (phase == '0) begin
            dut_rst     <= 1'b0;
            cycle_count <= '0;
            if (SETTLE_CYCLES == 0) begin
              state <= ST_WAIT;
            end else begin
              state <= ST_SETTLE;
              phase <= 32'(SETTLE_CYCLES - 1);
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end

        ST_SETTLE: begin
          cycle_count <= cc_next;
          if (timeout_hit) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else if (phase == '0) begin
            state <= ST_WAIT;
          end else begin
            phase <= phase - 1'b1;
          end
        end

        ST_WAIT: begin
          cycle_count <= cc_next;
          for (int k = 0; k < NUM_CH; k++) begin
            if (new_cap[k]) begin
              cap[k]       <= csr_ch[k];
              reported[k]  <= 1'b1;
              fail_mask[k] <= new_fail[k];
            end
          end
          // Completion is checked first so that a finish on the timeout cycle still passes.
          if (all_rep) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b0;
            pass    <= !any_fail;
          end else if (timeout_hit) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          dut_rst <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_test_monitor.sv
// Directed bench for csr_test_monitor.
// The DUT is configured with NUM_CH=2, TIMEOUT_CYCLES=100, hold=10, settle=10.
module tb_csr_test_monitor;

  localparam int NUM_CH    = 2;
  localparam int CSR_WIDTH = 32;
  localparam int CNT_WIDTH = 32;

  logic                        clk;
  logic                        rst;
  logic                        start;
  logic [NUM_CH*CSR_WIDTH-1:0] csr_in;
  logic [0:0]                  csr_sel;
  logic                        dut_rst;
  logic                        busy;
  logic                        done;
  logic                        pass;
  logic                        timeout;
  logic [NUM_CH-1:0]           reported;
  logic [NUM_CH-1:0]           fail_mask;
  logic [CSR_WIDTH-1:0]        csr_value;
  logic [CNT_WIDTH-1:0]        cycle_count;
  logic [2:0]                  dbg_state;

  int checks = 0;
  int errors = 0;
  int n_hold;

  csr_test_monitor #(
    .NUM_CH          (NUM_CH),
    .CSR_WIDTH       (CSR_WIDTH),
    .PASS_VALUE      (32'd1),
    .RST_HOLD_CYCLES (10),
    .SETTLE_CYCLES   (10),
    .TIMEOUT_CYCLES  (100),
    .CNT_WIDTH       (CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .csr_in      (csr_in),
    .csr_sel     (csr_sel),
    .dut_rst     (dut_rst),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .reported    (reported),
    .fail_mask   (fail_mask),
    .csr_value   (csr_value),
    .cycle_count (cycle_count),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_csr(input logic [31:0] ch1, input logic [31:0] ch0);
    csr_in = {ch1, ch0};
  endtask

  // Pulse start and return the number of cycles dut_rst stays high afterwards.
  task automatic do_start(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (dut_rst && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_cc(input int target);
    int n = 0;
    while (cycle_count != CNT_WIDTH'(target) && n < 300) begin
      tick();
      n++;
    end
    if (cycle_count != CNT_WIDTH'(target)) check("wait_cc", 64'(cycle_count), 64'(target));
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    csr_in  = '0;
    csr_sel = 1'b0;
    tick();
    tick();
    // Reset state.
    check("rst_dut_rst", 64'(dut_rst), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_reported", 64'(reported), 64'd0);
    check("rst_cc", 64'(cycle_count), 64'd0);
    rst = 1'b0;
    tick();

    // Run 1: both channels pass at cycle 50; a start pulse mid-run is ignored.
    do_start(n_hold);
    check("r1_hold_len", 64'(n_hold), 64'd10);
    check("r1_cc_at_release", 64'(cycle_count), 64'd0);
    check("r1_busy", 64'(busy), 64'd1);
    wait_cc(30);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r1_start_ignored_cc", 64'(cycle_count), 64'd31);
    check("r1_start_ignored_rst", 64'(dut_rst), 64'd0);
    wait_cc(50);
    set_csr(32'd1, 32'd1);
    tick();
    check("r1_done", 64'(done), 64'd1);
    check("r1_pass", 64'(pass), 64'd1);
    check("r1_timeout", 64'(timeout), 64'd0);
    check("r1_cc", 64'(cycle_count), 64'd51);
    check("r1_fail_mask", 64'(fail_mask), 64'd0);
    check("r1_busy_low", 64'(busy), 64'd0);
    set_csr(32'd0, 32'd0);
    tick();
    tick();
    check("r1_cc_frozen", 64'(cycle_count), 64'd51);

    // Run 2: ch0 passes first, then changes; ch1 reports 5.
    do_start(n_hold);
    check("r2_hold_len", 64'(n_hold), 64'd10);
    check("r2_cleared", 64'(reported), 64'd0);
    wait_cc(15);
    set_csr(32'd0, 32'd1);
    tick();
    check("r2_reported_partial", 64'(reported), 64'd1);
    check("r2_not_done", 64'(done), 64'd0);
    wait_cc(20);
    set_csr(32'd5, 32'd7);
    tick();
    check("r2_done", 64'(done), 64'd1);
    check("r2_pass", 64'(pass), 64'd0);
    check("r2_fail_mask", 64'(fail_mask), 64'd2);
    csr_sel = 1'b1;
    #1;
    check("r2_csr_value_ch1", 64'(csr_value), 64'd5);
    csr_sel = 1'b0;
    #1;
    check("r2_csr_value_ch0", 64'(csr_value), 64'd1);
    set_csr(32'd0, 32'd0);

    // Run 3: only ch0 reports, so the run times out at cycle 100.
    do_start(n_hold);
    wait_cc(30);
    set_csr(32'd0, 32'd1);
    wait_cc(99);
    check("r3_not_done_99", 64'(done), 64'd0);
    tick();
    check("r3_done", 64'(done), 64'd1);
    check("r3_cc", 64'(cycle_count), 64'd100);
    check("r3_timeout", 64'(timeout), 64'd1);
    check("r3_reported", 64'(reported), 64'd1);
    check("r3_pass", 64'(pass), 64'd0);
    check("r3_fail_mask", 64'(fail_mask), 64'd0);
    csr_sel = 1'b1;
    #1;
    check("r3_csr_value_ch1", 64'(csr_value), 64'd0);
    csr_sel = 1'b0;
    set_csr(32'd0, 32'd0);

    // Run 4: garbage during settle is ignored; the later value 1 is captured.
    do_start(n_hold);
    check("r4_hold_len", 64'(n_hold), 64'd10);
    wait_cc(3);
    set_csr(32'd9, 32'd9);
    wait_cc(5);
    set_csr(32'd0, 32'd0);
    wait_cc(12);
    check("r4_none_reported", 64'(reported), 64'd0);
    set_csr(32'd1, 32'd1);
    tick();
    check("r4_done", 64'(done), 64'd1);
    check("r4_pass", 64'(pass), 64'd1);
    check("r4_csr_value_ch0", 64'(csr_value), 64'd1);
    set_csr(32'd0, 32'd0);

    // Run 5: last channel reports on the cycle that would time out.
    do_start(n_hold);
    wait_cc(40);
    set_csr(32'd0, 32'd1);
    wait_cc(99);
    set_csr(32'd1, 32'd1);
    tick();
    check("r5_done", 64'(done), 64'd1);
    check("r5_pass", 64'(pass), 64'd1);
    check("r5_timeout", 64'(timeout), 64'd0);
    check("r5_cc", 64'(cycle_count), 64'd100);
    set_csr(32'd0, 32'd0);

    // Run 6: reset mid-run aborts; start is ignored while rst is high.
    do_start(n_hold);
    wait_cc(20);
    set_csr(32'd0, 32'd1);
    tick();
    check("r6_reported_before_rst", 64'(reported), 64'd1);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    set_csr(32'd0, 32'd0);
    check("r6_dut_rst", 64'(dut_rst), 64'd1);
    check("r6_busy", 64'(busy), 64'd0);
    check("r6_done", 64'(done), 64'd0);
    check("r6_reported", 64'(reported), 64'd0);
    check("r6_cc", 64'(cycle_count), 64'd0);
    check("r6_csr_value", 64'(csr_value), 64'd0);
    check("r6_state_idle", 64'(dbg_state), 64'd0);
    tick();
    check("r6_still_idle", 64'(busy), 64'd0);
    do_start(n_hold);
    check("r6_hold_len", 64'(n_hold), 64'd10);
    wait_cc(25);
    set_csr(32'd1, 32'd1);
    tick();
    check("r6_done_new", 64'(done), 64'd1);
    check("r6_pass_new", 64'(pass), 64'd1);
    check("r6_cc_new", 64'(cycle_count), 64'd26);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
